param_line_conv2d_engine: RTL and testbench

//  Parametrised line conv engine: streams one input line (all channels per pixel), slides a KERNEL_W-tap window,

---
 rtl/param_line_conv2d_engine.sv | 216 +++++++++++++++++++++
 tb/tb_param_line_conv2d_engine.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_line_conv2d_engine.sv
// Line convolution engine: streams one line of multi-channel pixels through a
// KERNEL_W-tap sliding window and produces NUM_KERNEL psums per full window,
// with optional psum accumulation, saturation, ReLU and valid/ready flow control.
module param_line_conv2d_engine #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int NUM_KERNEL  = 4,
  parameter int KERNEL_W    = 3,
  parameter int PSUM_WIDTH  = 32,
  parameter int SAT_EN      = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_clear,
  input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_weight,
  input  logic                                      i_weight_val,
  output logic                                      o_weight_rdy,
  input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]          i_data,
  input  logic                                      i_data_val,
  input  logic                                      i_data_last,
  output logic                                      o_data_rdy,
  input  logic [PSUM_WIDTH*NUM_KERNEL-1:0]          i_psum,
  input  logic                                      i_psum_en,
  input  logic                                      i_relu,
  output logic [PSUM_WIDTH*NUM_KERNEL-1:0]          o_psum,
  output logic                                      o_psum_val,
  output logic                                      o_psum_last,
  input  logic                                      i_psum_rdy,
  output logic [1:0]                                o_state,
  output logic                                      o_err_ovf
);

  localparam int WVEC  = BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL;
  localparam int PVEC  = BIT_WIDTH*NUM_CHANNEL;
  localparam int PRODW = 2*BIT_WIDTH;
  localparam int SUMW  = PSUM_WIDTH + $clog2(NUM_CHANNEL*KERNEL_W) + 2;
  localparam int TAPW  = (KERNEL_W > 1) ? $clog2(KERNEL_W) : 1;
  localparam int FILLW = $clog2(KERNEL_W+1);

  localparam logic [TAPW-1:0]        LAST_TAP = TAPW'(KERNEL_W-1);
  localparam logic [FILLW-1:0]       FULL     = FILLW'(KERNEL_W);
  localparam logic signed [SUMW-1:0] MAX_V    = {{(SUMW-PSUM_WIDTH+1){1'b0}}, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic signed [SUMW-1:0] MIN_V    = {{(SUMW-PSUM_WIDTH+1){1'b1}}, {(PSUM_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  state_t                   state_q;
  logic [TAPW-1:0]          tap_q;
  logic [WVEC-1:0]          weight_q [KERNEL_W];
  logic [PVEC-1:0]          window_q [KERNEL_W];
  logic [PVEC-1:0]          window_d [KERNEL_W];
  logic [FILLW-1:0]         fill_q;
  logic [FILLW-1:0]         fill_d;

  logic                     s1Val_q;
  logic                     s1Last_q;
  logic                     s1Relu_q;
  logic signed [PRODW-1:0]  prod_q [NUM_KERNEL][KERNEL_W][NUM_CHANNEL];
  logic signed [PRODW-1:0]  prod_d [NUM_KERNEL][KERNEL_W][NUM_CHANNEL];
  logic signed [PSUM_WIDTH-1:0] s1Psum_q [NUM_KERNEL];

  logic signed [SUMW-1:0]   acc_d [NUM_KERNEL];
  logic [PSUM_WIDTH-1:0]    res_d [NUM_KERNEL];
  logic [NUM_KERNEL-1:0]    ovf_d;

  logic [PSUM_WIDTH*NUM_KERNEL-1:0] psum_q;
  logic                     psumVal_q;
  logic                     psumLast_q;
  logic                     errOvf_q;

  logic en;
  logic dataRdy;
  logic accept;
  logic weightBeat;
  logic complete;

  // Handshake decode: the whole pipeline moves only when the output slot is free or being taken.
  always_comb begin
    en         = !psumVal_q || i_psum_rdy;
    dataRdy    = (state_q == RUN) && en && !i_clear;
    accept     = i_data_val && dataRdy;
    weightBeat = i_weight_val && (state_q != RUN) && !i_clear;
    fill_d     = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    complete   = accept && (fill_d == FULL);
  end

  // Next window: drop the oldest pixel at tap 0, append the incoming pixel at the newest tap.
  always_comb begin
    for (int i = 0; i < KERNEL_W - 1; i++) window_d[i] = window_q[i+1];
    window_d[KERNEL_W-1] = i_data;
  end

  // Per-kernel, per-tap, per-channel signed products over the window as it will be after this pixel.
  always_comb begin
    for (int k = 0; k < NUM_KERNEL; k++)
      for (int t = 0; t < KERNEL_W; t++)
        for (int c = 0; c < NUM_CHANNEL; c++)
          prod_d[k][t][c] = $signed(window_d[t][BIT_WIDTH*c +: BIT_WIDTH]) *
                            $signed(weight_q[t][BIT_WIDTH*(k*NUM_CHANNEL+c) +: BIT_WIDTH]);
  end

  // Wide accumulation, then saturate or wrap into PSUM_WIDTH, then ReLU.
  always_comb begin
    for (int k = 0; k < NUM_KERNEL; k++) begin
      acc_d[k] = SUMW'(s1Psum_q[k]);
      for (int t = 0; t < KERNEL_W; t++)
        for (int c = 0; c < NUM_CHANNEL; c++)
          acc_d[k] = acc_d[k] + SUMW'(prod_q[k][t][c]);
      ovf_d[k] = (acc_d[k] > MAX_V) || (acc_d[k] < MIN_V);
      if (ovf_d[k] && (SAT_EN != 0))
        res_d[k] = acc_d[k][SUMW-1] ? MIN_V[PSUM_WIDTH-1:0] : MAX_V[PSUM_WIDTH-1:0];
      else
        res_d[k] = acc_d[k][PSUM_WIDTH-1:0];
      if (s1Relu_q && res_d[k][PSUM_WIDTH-1])
        res_d[k] = '0;
    end
  end

  // Control FSM: weight taps arrive one per beat until all taps are loaded, then stream pixels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      for (int t = 0; t < KERNEL_W; t++) weight_q[t] <= '0;
    end else if (i_clear) begin
      state_q <= IDLE;
      tap_q   <= '0;
      for (int t = 0; t < KERNEL_W; t++) weight_q[t] <= '0;
    end else if (weightBeat) begin
      weight_q[tap_q] <= i_weight;
      if (tap_q == LAST_TAP) begin
        state_q <= RUN;
        tap_q   <= '0;
      end else begin
        state_q <= LOAD;
        tap_q   <= tap_q + 1'b1;
      end
    end
  end

  // Window and fill counter move only on accepted pixels; the last pixel of a line restarts the fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_q <= '0;
      for (int i = 0; i < KERNEL_W; i++) window_q[i] <= '0;
    end else if (i_clear) begin
      fill_q <= '0;
      for (int i = 0; i < KERNEL_W; i++) window_q[i] <= '0;
    end else if (accept) begin
      window_q <= window_d;
      fill_q   <= i_data_last ? '0 : fill_d;
    end
  end

  // Stage 1: register products, incoming psum and per-result controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1Val_q  <= 1'b0;
      s1Last_q <= 1'b0;
      s1Relu_q <= 1'b0;
      for (int k = 0; k < NUM_KERNEL; k++) begin
        s1Psum_q[k] <= '0;
        for (int t = 0; t < KERNEL_W; t++)
          for (int c = 0; c < NUM_CHANNEL; c++) prod_q[k][t][c] <= '0;
      end
    end else if (i_clear) begin
      s1Val_q  <= 1'b0;
      s1Last_q <= 1'b0;
      s1Relu_q <= 1'b0;
      for (int k = 0; k < NUM_KERNEL; k++) begin
        s1Psum_q[k] <= '0;
        for (int t = 0; t < KERNEL_W; t++)
          for (int c = 0; c < NUM_CHANNEL; c++) prod_q[k][t][c] <= '0;
      end
    end else if (en) begin
      s1Val_q  <= complete;
      s1Last_q <= i_data_last;
      s1Relu_q <= i_relu;
      prod_q   <= prod_d;
      for (int k = 0; k < NUM_KERNEL; k++)
        s1Psum_q[k] <= i_psum_en ? $signed(i_psum[PSUM_WIDTH*k +: PSUM_WIDTH]) : '0;
    end
  end

  // Stage 2: register the final result; overflow flag stays set until reset or clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psum_q     <= '0;
      psumVal_q  <= 1'b0;
      psumLast_q <= 1'b0;
      errOvf_q   <= 1'b0;
    end else if (i_clear) begin
      psum_q     <= '0;
      psumVal_q  <= 1'b0;
      psumLast_q <= 1'b0;
      errOvf_q   <= 1'b0;
    end else if (en) begin
      psumVal_q  <= s1Val_q;
      psumLast_q <= s1Val_q && s1Last_q;
      if (s1Val_q) begin
        for (int k = 0; k < NUM_KERNEL; k++)
          psum_q[PSUM_WIDTH*k +: PSUM_WIDTH] <= res_d[k];
        errOvf_q <= errOvf_q || (|ovf_d);
      end
    end
  end

  assign o_weight_rdy = rst && (state_q != RUN);
  assign o_data_rdy   = dataRdy;
  assign o_psum       = psum_q;
  assign o_psum_val   = psumVal_q;
  assign o_psum_last  = psumLast_q;
  assign o_state      = state_q;
  assign o_err_ovf    = errOvf_q;

endmodule

// File: tb/tb_param_line_conv2d_engine.sv
// Directed testbench for param_line_conv2d_engine: one default-size engine plus two
// 16-bit psum engines (saturating and wrapping) sharing the same stimulus.
module tb_param_line_conv2d_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_clear;
  logic [95:0]  i_weight;
  logic         i_weight_val;
  logic [23:0]  i_data;
  logic         i_data_val;
  logic         i_data_last;
  logic [127:0] i_psum;
  logic [63:0]  psum16;
  logic         i_psum_en;
  logic         i_relu;
  logic         i_psum_rdy;

  logic         o_weight_rdy, o_data_rdy, o_psum_val, o_psum_last, o_err_ovf;
  logic [127:0] o_psum;
  logic [1:0]   o_state;

  logic         satWRdy, satDRdy, satVal, satLast, satOvf;
  logic [63:0]  satPsum;
  logic [1:0]   satState;
  logic         wrapWRdy, wrapDRdy, wrapVal, wrapLast, wrapOvf;
  logic [63:0]  wrapPsum;
  logic [1:0]   wrapState;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastAcceptCyc = 0;
  int popCyc = 0;
  logic [15:0] popSat = '0;
  logic [15:0] popWrap = '0;

  logic [127:0] outQ[$];
  logic         lastQ[$];
  int           cycQ[$];
  logic [15:0]  satQ[$];
  logic [15:0]  wrapQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_line_conv2d_engine dut (
    .clk(clk), .rst(rst), .i_clear(i_clear),
    .i_weight(i_weight), .i_weight_val(i_weight_val), .o_weight_rdy(o_weight_rdy),
    .i_data(i_data), .i_data_val(i_data_val), .i_data_last(i_data_last), .o_data_rdy(o_data_rdy),
    .i_psum(i_psum), .i_psum_en(i_psum_en), .i_relu(i_relu),
    .o_psum(o_psum), .o_psum_val(o_psum_val), .o_psum_last(o_psum_last), .i_psum_rdy(i_psum_rdy),
    .o_state(o_state), .o_err_ovf(o_err_ovf)
  );

  param_line_conv2d_engine #(.PSUM_WIDTH(16), .SAT_EN(1)) dutSat (
    .clk(clk), .rst(rst), .i_clear(i_clear),
    .i_weight(i_weight), .i_weight_val(i_weight_val), .o_weight_rdy(satWRdy),
    .i_data(i_data), .i_data_val(i_data_val), .i_data_last(i_data_last), .o_data_rdy(satDRdy),
    .i_psum(psum16), .i_psum_en(i_psum_en), .i_relu(i_relu),
    .o_psum(satPsum), .o_psum_val(satVal), .o_psum_last(satLast), .i_psum_rdy(i_psum_rdy),
    .o_state(satState), .o_err_ovf(satOvf)
  );

  param_line_conv2d_engine #(.PSUM_WIDTH(16), .SAT_EN(0)) dutWrap (
    .clk(clk), .rst(rst), .i_clear(i_clear),
    .i_weight(i_weight), .i_weight_val(i_weight_val), .o_weight_rdy(wrapWRdy),
    .i_data(i_data), .i_data_val(i_data_val), .i_data_last(i_data_last), .o_data_rdy(wrapDRdy),
    .i_psum(psum16), .i_psum_en(i_psum_en), .i_relu(i_relu),
    .o_psum(wrapPsum), .o_psum_val(wrapVal), .o_psum_last(wrapLast), .i_psum_rdy(i_psum_rdy),
    .o_state(wrapState), .o_err_ovf(wrapOvf)
  );

  // Capture every result that is handed downstream, with the cycle it appeared in.
  always @(negedge clk) begin
    if (rst && o_psum_val && i_psum_rdy) begin
      outQ.push_back(o_psum);
      lastQ.push_back(o_psum_last);
      cycQ.push_back(cyc);
      satQ.push_back(satPsum[15:0]);
      wrapQ.push_back(wrapPsum[15:0]);
    end
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic clearEngine();
    i_clear = 1'b1;
    stepCycle();
    i_clear = 1'b0;
    outQ.delete(); lastQ.delete(); cycQ.delete(); satQ.delete(); wrapQ.delete();
  endtask

  task automatic loadWeights(input logic [95:0] t0, input logic [95:0] t1, input logic [95:0] t2);
    i_weight_val = 1'b1;
    i_weight = t0; stepCycle();
    i_weight = t1; stepCycle();
    i_weight = t2; stepCycle();
    i_weight_val = 1'b0;
    i_weight = '0;
  endtask

  // Present one pixel and hold it until the engine takes it (bounded).
  task automatic applyStimulus(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2, input logic last);
    logic got;
    int   n;
    got = 1'b0;
    n = 0;
    i_data = {c2, c1, c0};
    i_data_val = 1'b1;
    i_data_last = last;
    while (!got && n < 50) begin
      @(negedge clk);
      got = o_data_rdy;
      lastAcceptCyc = cyc;
      stepCycle();
      n++;
    end
    i_data_val = 1'b0;
    i_data_last = 1'b0;
    checkOutput("pixelAccepted", 64'(got), 64'(1));
  endtask

  task automatic expectResult(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3, input logic eLast);
    logic [127:0] v;
    logic         l;
    checkOutput({tag, "_present"}, 64'(outQ.size() != 0), 64'(1));
    if (outQ.size() != 0) begin
      v = outQ.pop_front();
      l = lastQ.pop_front();
      popCyc = cycQ.pop_front();
      popSat = satQ.pop_front();
      popWrap = wrapQ.pop_front();
      checkOutput({tag, "_k0"}, 64'(v[31:0]), 64'(e0));
      checkOutput({tag, "_k1"}, 64'(v[63:32]), 64'(e1));
      checkOutput({tag, "_k2"}, 64'(v[95:64]), 64'(e2));
      checkOutput({tag, "_k3"}, 64'(v[127:96]), 64'(e3));
      checkOutput({tag, "_last"}, 64'(l), 64'(eLast));
    end
  endtask

  logic [95:0] ones;
  logic [95:0] tapA;
  logic [95:0] tapC;
  int acc3;
  int firstCyc;

  initial begin
    rst = 1'b0; i_clear = 1'b0; i_weight = '0; i_weight_val = 1'b0;
    i_data = '0; i_data_val = 1'b0; i_data_last = 1'b0;
    i_psum = '0; psum16 = '0; i_psum_en = 1'b0; i_relu = 1'b0; i_psum_rdy = 1'b1;
    ones = {12{8'd1}};

    // Reset values while held in reset.
    #3;
    checkOutput("rstPsumVal", 64'(o_psum_val), 64'(0));
    checkOutput("rstPsum", 64'(o_psum[63:0]), 64'(0));
    checkOutput("rstState", 64'(o_state), 64'(0));
    checkOutput("rstWeightRdy", 64'(o_weight_rdy), 64'(0));
    checkOutput("rstDataRdy", 64'(o_data_rdy), 64'(0));
    checkOutput("rstOvf", 64'(o_err_ovf), 64'(0));
    waitCycles(2);
    rst = 1'b1;
    stepCycle();
    checkOutput("postRstWeightRdy", 64'(o_weight_rdy), 64'(1));

    // Clear wins over a simultaneous weight beat.
    i_clear = 1'b1; i_weight_val = 1'b1; i_weight = ones;
    stepCycle();
    i_clear = 1'b0; i_weight_val = 1'b0;
    checkOutput("clearBeatState", 64'(o_state), 64'(0));

    // Test 1: unit weights, ramp 1..5, latency and throughput.
    $display("[TB] test 1: unit weights, ramp line");
    clearEngine();
    i_weight_val = 1'b1; i_weight = ones; stepCycle();
    checkOutput("t1StateLoad", 64'(o_state), 64'(1));
    stepCycle(); stepCycle();
    i_weight_val = 1'b0;
    checkOutput("t1StateRun", 64'(o_state), 64'(2));
    checkOutput("t1WeightRdy", 64'(o_weight_rdy), 64'(0));
    applyStimulus(1, 1, 1, 0);
    applyStimulus(2, 2, 2, 0);
    applyStimulus(3, 3, 3, 0);
    acc3 = lastAcceptCyc;
    applyStimulus(4, 4, 4, 0);
    applyStimulus(5, 5, 5, 1);
    waitCycles(6);
    expectResult("t1a", 18, 18, 18, 18, 0);
    checkOutput("t1Latency", 64'(popCyc - acc3), 64'(2));
    firstCyc = popCyc;
    expectResult("t1b", 27, 27, 27, 27, 0);
    checkOutput("t1Throughput", 64'(popCyc - firstCyc), 64'(1));
    expectResult("t1c", 36, 36, 36, 36, 1);
    checkOutput("t1Extra", 64'(outQ.size()), 64'(0));

    // Test 2: downstream stall after the first result.
    $display("[TB] test 2: backpressure");
    clearEngine();
    loadWeights(ones, ones, ones);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(2, 2, 2, 0);
    applyStimulus(3, 3, 3, 0);
    i_psum_rdy = 1'b0;
    fork
      begin
        applyStimulus(4, 4, 4, 0);
        applyStimulus(5, 5, 5, 1);
      end
      begin
        waitCycles(4);
        @(negedge clk);
        checkOutput("t2HeldVal", 64'(o_psum_val), 64'(1));
        checkOutput("t2Held18", 64'(o_psum[31:0]), 64'(18));
        checkOutput("t2DataRdy", 64'(o_data_rdy), 64'(0));
        waitCycles(3);
        @(negedge clk);
        checkOutput("t2StillHeld", 64'(o_psum[127:96]), 64'(18));
        checkOutput("t2HeldLast", 64'(o_psum_last), 64'(0));
        stepCycle();
        i_psum_rdy = 1'b1;
      end
    join
    waitCycles(6);
    expectResult("t2a", 18, 18, 18, 18, 0);
    expectResult("t2b", 27, 27, 27, 27, 0);
    expectResult("t2c", 36, 36, 36, 36, 1);
    checkOutput("t2Extra", 64'(outQ.size()), 64'(0));

    // Test 3: 16-bit psum overflow, saturating versus wrapping.
    $display("[TB] test 3: overflow");
    clearEngine();
    loadWeights({12{8'd127}}, {12{8'd127}}, {12{8'd127}});
    i_psum_en = 1'b1;
    i_psum = {4{32'd32767}};
    psum16 = {4{16'h7FFF}};
    applyStimulus(127, 127, 127, 0);
    applyStimulus(127, 127, 127, 0);
    applyStimulus(127, 127, 127, 1);
    i_psum_en = 1'b0;
    waitCycles(6);
    expectResult("t3Wide", 177928, 177928, 177928, 177928, 1);
    checkOutput("t3Sat", 64'(popSat), 64'(16'h7FFF));
    checkOutput("t3Wrap", 64'(popWrap), 64'(16'hB708));
    checkOutput("t3SatOvf", 64'(satOvf), 64'(1));
    checkOutput("t3WrapOvf", 64'(wrapOvf), 64'(1));
    checkOutput("t3WideOvf", 64'(o_err_ovf), 64'(0));
    waitCycles(3);
    checkOutput("t3Sticky", 64'(satOvf), 64'(1));
    clearEngine();
    checkOutput("t3OvfCleared", 64'(satOvf), 64'(0));

    // Test 4: negative results with and without ReLU.
    $display("[TB] test 4: relu");
    loadWeights({12{8'hFF}}, {12{8'hFF}}, {12{8'hFF}});
    i_relu = 1'b1;
    applyStimulus(2, 2, 2, 0);
    applyStimulus(2, 2, 2, 0);
    applyStimulus(2, 2, 2, 1);
    i_relu = 1'b0;
    applyStimulus(2, 2, 2, 0);
    applyStimulus(2, 2, 2, 0);
    applyStimulus(2, 2, 2, 1);
    waitCycles(6);
    expectResult("t4Relu", 0, 0, 0, 0, 1);
    expectResult("t4Neg", 32'hFFFFFFEE, 32'hFFFFFFEE, 32'hFFFFFFEE, 32'hFFFFFFEE, 1);

    // Test 5: short line produces nothing, next line restarts the window.
    $display("[TB] test 5: short line");
    clearEngine();
    loadWeights(ones, ones, ones);
    applyStimulus(5, 5, 5, 0);
    applyStimulus(5, 5, 5, 1);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 1, 1, 1);
    waitCycles(6);
    checkOutput("t5Count", 64'(outQ.size()), 64'(1));
    expectResult("t5", 9, 9, 9, 9, 1);
    checkOutput("t5Ovf", 64'(o_err_ovf), 64'(0));

    // Test 7: distinct weights per kernel/tap/channel with per-kernel psum.
    $display("[TB] test 7: kernel/tap/channel ordering");
    clearEngine();
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 3; c++) begin
        tapA[8*(k*3+c) +: 8] = 8'(k + 1);
        tapC[8*(k*3+c) +: 8] = 8'(c);
      end
    loadWeights(tapA, 96'd0, tapC);
    i_psum_en = 1'b1;
    i_relu = 1'b1;
    i_psum = {32'd300, 32'd200, 32'd100, 32'd0};
    applyStimulus(1, 2, 3, 0);
    applyStimulus(4, 5, 6, 0);
    applyStimulus(7, 8, 9, 1);
    i_psum_en = 1'b0;
    i_relu = 1'b0;
    i_psum = '0;
    waitCycles(6);
    expectResult("t7", 32, 138, 244, 350, 1);

    // Test 6: asynchronous reset with a result pending, then reload.
    $display("[TB] test 6: reset mid-run");
    clearEngine();
    loadWeights(ones, ones, ones);
    i_psum_rdy = 1'b0;
    applyStimulus(1, 1, 1, 0);
    applyStimulus(2, 2, 2, 0);
    applyStimulus(3, 3, 3, 0);
    waitCycles(3);
    checkOutput("t6Pending", 64'(o_psum_val), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t6Val", 64'(o_psum_val), 64'(0));
    checkOutput("t6Psum", 64'(o_psum[127:64]), 64'(0));
    checkOutput("t6State", 64'(o_state), 64'(0));
    checkOutput("t6DataRdy", 64'(o_data_rdy), 64'(0));
    checkOutput("t6WeightRdy", 64'(o_weight_rdy), 64'(0));
    i_psum_rdy = 1'b1;
    waitCycles(1);
    rst = 1'b1;
    stepCycle();
    checkOutput("t6WeightRdyBack", 64'(o_weight_rdy), 64'(1));
    i_data = {3{8'd1}};
    i_data_val = 1'b1;
    i_weight_val = 1'b1;
    i_weight = ones;
    stepCycle();
    stepCycle();
    checkOutput("t6RefusedState", 64'(o_state), 64'(1));
    checkOutput("t6Refused", 64'(o_data_rdy), 64'(0));
    stepCycle();
    i_weight_val = 1'b0;
    checkOutput("t6Reloaded", 64'(o_state), 64'(2));
    checkOutput("t6DataRdyRun", 64'(o_data_rdy), 64'(1));
    i_data_val = 1'b0;
    waitCycles(4);
    checkOutput("t6NoOutput", 64'(outQ.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
